// File: rtl/id_stage_if.sv
// id_stage_if: pipeline-side bundle of the decode stage.
//   Fetch handshake : if_valid, if_instr, if_pc (to ID), id_ready (from ID)
//   Execute control : flush, ex_ready (to ID)
//   ID/EX register  : ex_valid, ex_pc, ex_rs1_val, ex_rs2_val, ex_rs3_val,
//                     ex_imm, ex_rd, ex_rd_we, ex_opcode, ex_funct3,
//                     ex_funct7, ex_is_mac, ex_illegal (from ID)
// Modports: master = decode stage, slave = fetch/execute side.
interface id_stage_if;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        id_ready;
    logic        flush;
    logic        ex_ready;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [31:0] ex_rs1_val;
    logic [31:0] ex_rs2_val;
    logic [31:0] ex_rs3_val;
    logic [31:0] ex_imm;
    logic [4:0]  ex_rd;
    logic        ex_rd_we;
    logic [6:0]  ex_opcode;
    logic [2:0]  ex_funct3;
    logic [6:0]  ex_funct7;
    logic        ex_is_mac;
    logic        ex_illegal;

    modport master (
        input  if_valid, if_instr, if_pc, flush, ex_ready,
        output id_ready, ex_valid, ex_pc, ex_rs1_val, ex_rs2_val, ex_rs3_val,
               ex_imm, ex_rd, ex_rd_we, ex_opcode, ex_funct3, ex_funct7,
               ex_is_mac, ex_illegal
    );

    modport slave (
        output if_valid, if_instr, if_pc, flush, ex_ready,
        input  id_ready, ex_valid, ex_pc, ex_rs1_val, ex_rs2_val, ex_rs3_val,
               ex_imm, ex_rd, ex_rd_we, ex_opcode, ex_funct3, ex_funct7,
               ex_is_mac, ex_illegal
    );
endinterface

// File: rtl/id_stage.sv
// id_stage: instruction decode for RV32I plus the custom 3-source MAC.
// Decodes one instruction per cycle, drives three register-file read ports,
// tracks pending destination writes in a 32-entry scoreboard (cleared by
// snooping write-back) and stalls on RAW/WAW hazards.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   pipe (id_stage_if.master)  fetch handshake, flush/ex_ready, ID/EX register
//   rN_read_enable, rN_addr    register-file read requests (N = 1..3)
//   rN_data                    combinational register-file read data
//   wb_write_enable, wb_w_addr, wb_w_data   write-back snoop port
// Configuration macro: WB_BYPASS_EN (forward write-back data into decode).
module id_stage (
    input  logic              clk,
    input  logic              reset,
    id_stage_if.master        pipe,
    output logic              r1_read_enable,
    output logic              r2_read_enable,
    output logic              r3_read_enable,
    output logic [4:0]        r1_addr,
    output logic [4:0]        r2_addr,
    output logic [4:0]        r3_addr,
    input  logic [31:0]       r1_data,
    input  logic [31:0]       r2_data,
    input  logic [31:0]       r3_data,
    input  logic              wb_write_enable,
    input  logic [4:0]        wb_w_addr,
    input  logic [31:0]       wb_w_data
);
    typedef enum logic [6:0] {
        OPC_OP     = 7'b0110011,
        OPC_OP_IMM = 7'b0010011,
        OPC_LOAD   = 7'b0000011,
        OPC_JALR   = 7'b1100111,
        OPC_STORE  = 7'b0100011,
        OPC_BRANCH = 7'b1100011,
        OPC_LUI    = 7'b0110111,
        OPC_AUIPC  = 7'b0010111,
        OPC_JAL    = 7'b1101111,
        OPC_MAC    = 7'b0001011
    } opcode_e;

    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [4:0]  rs1, rs2, rs3, rd;
    logic        use1, use2, use3, use_rd, is_mac, illegal;
    logic [31:0] imm;
    logic        valid_in, re1, re2, re3, rd_we;
    logic        wb_live, byp1, byp2, byp3, byp_rd;
    logic [31:0] val1, val2, val3;
    logic        hazard, issue;
    logic [31:0] pending, pending_nxt;
    logic        ex_valid_q, ex_rd_we_q;
    logic [4:0]  ex_rd_q;

    assign instr  = pipe.if_instr;
    assign opcode = instr[6:0];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign rs3    = instr[31:27];
    assign rd     = instr[11:7];

    always_comb begin
        use1    = 1'b0;
        use2    = 1'b0;
        use3    = 1'b0;
        use_rd  = 1'b0;
        is_mac  = 1'b0;
        illegal = 1'b0;
        imm     = '0;
        case (opcode)
            OPC_OP: begin
                use1 = 1'b1; use2 = 1'b1; use_rd = 1'b1;
            end
            OPC_OP_IMM, OPC_LOAD, OPC_JALR: begin
                use1 = 1'b1; use_rd = 1'b1;
                imm  = {{20{instr[31]}}, instr[31:20]};
            end
            OPC_STORE: begin
                use1 = 1'b1; use2 = 1'b1;
                imm  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            end
            OPC_BRANCH: begin
                use1 = 1'b1; use2 = 1'b1;
                imm  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                        instr[11:8], 1'b0};
            end
            OPC_LUI, OPC_AUIPC: begin
                use_rd = 1'b1;
                imm    = {instr[31:12], 12'b0};
            end
            OPC_JAL: begin
                use_rd = 1'b1;
                imm    = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                          instr[30:21], 1'b0};
            end
            OPC_MAC: begin
                use1 = 1'b1; use2 = 1'b1; use3 = 1'b1; use_rd = 1'b1;
                is_mac = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
    end

    assign valid_in = pipe.if_valid & ~reset;
    assign re1      = use1 & valid_in;
    assign re2      = use2 & valid_in;
    assign re3      = use3 & valid_in;
    assign rd_we    = use_rd & (rd != 5'd0);

    assign r1_read_enable = re1;
    assign r2_read_enable = re2;
    assign r3_read_enable = re3;
    assign r1_addr        = rs1;
    assign r2_addr        = rs2;
    assign r3_addr        = rs3;

    assign wb_live = wb_write_enable & (wb_w_addr != 5'd0);
`ifdef WB_BYPASS_EN
    assign byp1   = wb_live & (wb_w_addr == rs1);
    assign byp2   = wb_live & (wb_w_addr == rs2);
    assign byp3   = wb_live & (wb_w_addr == rs3);
    assign byp_rd = wb_live & (wb_w_addr == rd);
`else
    assign byp1   = 1'b0;
    assign byp2   = 1'b0;
    assign byp3   = 1'b0;
    assign byp_rd = 1'b0;
`endif

    assign val1 = byp1 ? wb_w_data : r1_data;
    assign val2 = byp2 ? wb_w_data : r2_data;
    assign val3 = byp3 ? wb_w_data : r3_data;

    // pending[0] is held at zero, so x0 sources and destinations never stall.
    assign hazard = (re1 & pending[rs1] & ~byp1)
                  | (re2 & pending[rs2] & ~byp2)
                  | (re3 & pending[rs3] & ~byp3)
                  | (valid_in & rd_we & pending[rd] & ~byp_rd);

    assign issue = valid_in & ~hazard & ~pipe.flush & (~ex_valid_q | pipe.ex_ready);
    assign pipe.id_ready = issue;

    // Clears are applied before the issue set so a same-register set wins.
    always_comb begin
        pending_nxt = pending;
        if (wb_live)
            pending_nxt[wb_w_addr] = 1'b0;
        if (pipe.flush && ex_valid_q && ex_rd_we_q)
            pending_nxt[ex_rd_q] = 1'b0;
        if (issue && rd_we)
            pending_nxt[rd] = 1'b1;
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending         <= '0;
            ex_valid_q      <= 1'b0;
            ex_rd_q         <= '0;
            ex_rd_we_q      <= 1'b0;
            pipe.ex_pc      <= '0;
            pipe.ex_rs1_val <= '0;
            pipe.ex_rs2_val <= '0;
            pipe.ex_rs3_val <= '0;
            pipe.ex_imm     <= '0;
            pipe.ex_opcode  <= '0;
            pipe.ex_funct3  <= '0;
            pipe.ex_funct7  <= '0;
            pipe.ex_is_mac  <= 1'b0;
            pipe.ex_illegal <= 1'b0;
        end else begin
            pending <= pending_nxt;
            if (pipe.flush) begin
                ex_valid_q <= 1'b0;
            end else if (issue) begin
                ex_valid_q      <= 1'b1;
                ex_rd_q         <= rd;
                ex_rd_we_q      <= rd_we;
                pipe.ex_pc      <= pipe.if_pc;
                pipe.ex_rs1_val <= val1;
                pipe.ex_rs2_val <= val2;
                pipe.ex_rs3_val <= val3;
                pipe.ex_imm     <= imm;
                pipe.ex_opcode  <= opcode;
                pipe.ex_funct3  <= instr[14:12];
                pipe.ex_funct7  <= instr[31:25];
                pipe.ex_is_mac  <= is_mac;
                pipe.ex_illegal <= illegal;
            end else if (pipe.ex_ready) begin
                ex_valid_q <= 1'b0;
            end
        end
    end

    assign pipe.ex_valid = ex_valid_q;
    assign pipe.ex_rd    = ex_rd_q;
    assign pipe.ex_rd_we = ex_rd_we_q;
endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed bench for id_stage with a register-file model and an
// expected-entry queue compared against the ID/EX register after each issue.
module tb_id_stage;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        r1_read_enable, r2_read_enable, r3_read_enable;
    logic [4:0]  r1_addr, r2_addr, r3_addr;
    logic [31:0] r1_data, r2_data, r3_data;
    logic        wb_write_enable;
    logic [4:0]  wb_w_addr;
    logic [31:0] wb_w_data;
    logic [31:0] regs [32];

    id_stage_if pipe();

    id_stage dut (
        .clk(clk), .reset(reset), .pipe(pipe),
        .r1_read_enable(r1_read_enable), .r2_read_enable(r2_read_enable),
        .r3_read_enable(r3_read_enable),
        .r1_addr(r1_addr), .r2_addr(r2_addr), .r3_addr(r3_addr),
        .r1_data(r1_data), .r2_data(r2_data), .r3_data(r3_data),
        .wb_write_enable(wb_write_enable), .wb_w_addr(wb_w_addr),
        .wb_w_data(wb_w_data)
    );

    assign r1_data = regs[r1_addr];
    assign r2_data = regs[r2_addr];
    assign r3_data = regs[r3_addr];
    always @(posedge clk)
        if (wb_write_enable && wb_w_addr != 5'd0) regs[wb_w_addr] <= wb_w_data;

    typedef struct {
        logic [31:0] pc;  logic [6:0] op;
        logic [4:0]  rd;  logic cr;  logic we;
        logic [31:0] imm; logic ci;  logic mac; logic ill;
        logic c1; logic [31:0] v1;
        logic c2; logic [31:0] v2;
        logic c3; logic [31:0] v3;
    } exp_t;

    exp_t q[$];
    exp_t none;
    int errors = 0;
    int checks = 0;

    localparam logic [6:0] OP = 7'b0110011, OPIMM = 7'b0010011, LOAD = 7'b0000011;
    localparam logic [6:0] STORE = 7'b0100011, BRANCH = 7'b1100011, LUI = 7'b0110111;
    localparam logic [6:0] JAL = 7'b1101111, MAC = 7'b0001011;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(logic [31:0] pc, logic [6:0] op, logic [4:0] rd, logic cr,
                                logic we, logic [31:0] imm, logic ci, logic mac, logic ill,
                                logic c1, logic [31:0] v1, logic c2, logic [31:0] v2,
                                logic c3, logic [31:0] v3);
        exp_t e;
        e.pc = pc; e.op = op; e.rd = rd; e.cr = cr; e.we = we; e.imm = imm; e.ci = ci;
        e.mac = mac; e.ill = ill; e.c1 = c1; e.v1 = v1; e.c2 = c2; e.v2 = v2;
        e.c3 = c3; e.v3 = v3;
        return e;
    endfunction

    function automatic logic [31:0] enc_i(logic [11:0] imm, logic [4:0] rs1, logic [2:0] f3,
                                          logic [4:0] rd, logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] enc_r(logic [4:0] rs2, logic [4:0] rs1, logic [4:0] rd);
        return {7'b0, rs2, rs1, 3'b000, rd, OP};
    endfunction
    function automatic logic [31:0] enc_mac(logic [4:0] rs3, logic [4:0] rs2, logic [4:0] rs1,
                                            logic [4:0] rd);
        return {rs3, 2'b00, rs2, rs1, 3'b000, rd, MAC};
    endfunction
    function automatic logic [31:0] enc_s(logic [11:0] imm, logic [4:0] rs2, logic [4:0] rs1);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], STORE};
    endfunction
    function automatic logic [31:0] enc_b(logic [12:0] imm, logic [4:0] rs2, logic [4:0] rs1);
        return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], BRANCH};
    endfunction
    function automatic logic [31:0] enc_j(logic [20:0] imm, logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, JAL};
    endfunction

    // Advance one edge; compare the ID/EX register against the queued entry.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (q.size() != 0) begin
            e = q.pop_front();
            chk("ex_valid", pipe.ex_valid, 1);
            chk("ex_pc", pipe.ex_pc, e.pc);
            chk("ex_opcode", pipe.ex_opcode, e.op);
            chk("ex_rd_we", pipe.ex_rd_we, e.we);
            chk("ex_is_mac", pipe.ex_is_mac, e.mac);
            chk("ex_illegal", pipe.ex_illegal, e.ill);
            if (e.cr) chk("ex_rd", pipe.ex_rd, e.rd);
            if (e.ci) chk("ex_imm", pipe.ex_imm, e.imm);
            if (e.c1) chk("ex_rs1_val", pipe.ex_rs1_val, e.v1);
            if (e.c2) chk("ex_rs2_val", pipe.ex_rs2_val, e.v2);
            if (e.c3) chk("ex_rs3_val", pipe.ex_rs3_val, e.v3);
        end
        pipe.if_valid   = 1'b0;
        pipe.flush      = 1'b0;
        wb_write_enable = 1'b0;
    endtask

    task automatic offer(input logic [31:0] instr, input logic [31:0] pc, input logic rdy,
                         input exp_t e);
        pipe.if_valid = 1'b1;
        pipe.if_instr = instr;
        pipe.if_pc    = pc;
        #1;
        chk("id_ready", pipe.id_ready, rdy);
        if (rdy) q.push_back(e);
    endtask

    task automatic read_en(input string tag, input logic e1, input logic e2, input logic e3);
        chk({tag, "_re"}, {r1_read_enable, r2_read_enable, r3_read_enable}, {e1, e2, e3});
    endtask

    initial begin
        none = mk('0, '0, '0, 0, 0, '0, 0, 0, 0, 0, '0, 0, '0, 0, '0);
        for (int i = 0; i < 32; i++) regs[i] = '0;
        regs[1] = 32'd2; regs[2] = 32'd3; regs[4] = 32'd10; regs[5] = 32'd99;
        reset = 1'b1; pipe.flush = 1'b0; pipe.ex_ready = 1'b1;
        wb_write_enable = 1'b0; wb_w_addr = '0; wb_w_data = '0;
        pipe.if_valid = 1'b1; pipe.if_instr = enc_r(5'd5, 5'd5, 5'd6); pipe.if_pc = 32'h40;

        // Reset state, with an instruction offered that must be dropped
        @(posedge clk); @(posedge clk); #1;
        read_en("reset", 0, 0, 0);
        chk("rst_ex_valid", pipe.ex_valid, 0);
        chk("rst_ex_pc", pipe.ex_pc, 0);
        chk("rst_ex_rd", pipe.ex_rd, 0);
        chk("rst_ex_rd_we", pipe.ex_rd_we, 0);
        chk("rst_ex_imm", pipe.ex_imm, 0);
        chk("rst_ex_rs1", pipe.ex_rs1_val, 0);
        chk("rst_ex_flags", {pipe.ex_is_mac, pipe.ex_illegal, pipe.ex_opcode}, 0);
        reset = 1'b0; pipe.if_valid = 1'b0;

        // ADDI x5,x0,7
        offer(enc_i(12'd7, 5'd0, 3'd0, 5'd5, OPIMM), 32'h100, 1,
              mk(32'h100, OPIMM, 5'd5, 1, 1, 32'd7, 1, 0, 0, 1, 0, 0, 0, 0, 0));
        read_en("addi", 1, 0, 0);
        tick();

        // ADD x6,x5,x5 stalls on pending x5; the ID/EX entry drains
        offer(enc_r(5'd5, 5'd5, 5'd6), 32'h104, 0, none);
        tick();
        chk("drain_ex_valid", pipe.ex_valid, 0);
        wb_write_enable = 1'b1; wb_w_addr = 5'd5; wb_w_data = 32'd7;
`ifdef WB_BYPASS_EN
        offer(enc_r(5'd5, 5'd5, 5'd6), 32'h104, 1,
              mk(32'h104, OP, 5'd6, 1, 1, 0, 0, 0, 0, 1, 32'd7, 1, 32'd7, 0, 0));
        tick();
`else
        offer(enc_r(5'd5, 5'd5, 5'd6), 32'h104, 0, none);
        tick();
        offer(enc_r(5'd5, 5'd5, 5'd6), 32'h104, 1,
              mk(32'h104, OP, 5'd6, 1, 1, 0, 0, 0, 0, 1, 32'd7, 1, 32'd7, 0, 0));
        tick();
`endif

        // MAC x3 = x1,x2,x4
        offer(enc_mac(5'd4, 5'd2, 5'd1, 5'd3), 32'h108, 1,
              mk(32'h108, MAC, 5'd3, 1, 1, 0, 0, 1, 0, 1, 32'd2, 1, 32'd3, 1, 32'd10));
        read_en("mac", 1, 1, 1);
        chk("mac_r3_addr", r3_addr, 5'd4);
        tick();
        chk("mac_funct7", pipe.ex_funct7, 7'b0010000);

        // Back-pressure: entry held for 3 cycles, then next issues
        pipe.ex_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            offer(enc_i(12'd1, 5'd0, 3'd0, 5'd7, OPIMM), 32'h10c, 0, none);
            tick();
            chk("hold_ex_valid", pipe.ex_valid, 1);
            chk("hold_ex_pc", pipe.ex_pc, 32'h108);
            chk("hold_ex_rs3", pipe.ex_rs3_val, 32'd10);
        end
        pipe.ex_ready = 1'b1;
        offer(enc_i(12'd1, 5'd0, 3'd0, 5'd7, OPIMM), 32'h10c, 1,
              mk(32'h10c, OPIMM, 5'd7, 1, 1, 32'd1, 1, 0, 0, 1, 0, 0, 0, 0, 0));
        tick();

        // Immediate formats, back to back
        offer(enc_s(12'hFFC, 5'd2, 5'd1), 32'h110, 1,
              mk(32'h110, STORE, 0, 0, 0, 32'hFFFFFFFC, 1, 0, 0, 1, 32'd2, 1, 32'd3, 0, 0));
        read_en("store", 1, 1, 0);
        tick();
        offer(enc_b(13'h1FF8, 5'd2, 5'd1), 32'h114, 1,
              mk(32'h114, BRANCH, 0, 0, 0, 32'hFFFFFFF8, 1, 0, 0, 1, 32'd2, 1, 32'd3, 0, 0));
        tick();
        offer(enc_j(21'h000800, 5'd8), 32'h118, 1,
              mk(32'h118, JAL, 5'd8, 1, 1, 32'h800, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        read_en("jal", 0, 0, 0);
        tick();
        offer({20'hABCDE, 5'd12, LUI}, 32'h11c, 1,
              mk(32'h11c, LUI, 5'd12, 1, 1, 32'hABCDE000, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        tick();
        offer(enc_i(12'h7FF, 5'd4, 3'b010, 5'd14, LOAD), 32'h120, 1,
              mk(32'h120, LOAD, 5'd14, 1, 1, 32'h7FF, 1, 0, 0, 1, 32'd10, 0, 0, 0, 0));
        tick();

        // Illegal opcode issues without reads or destination write
        offer({20'h12345, 5'd15, 7'h7F}, 32'h124, 1,
              mk(32'h124, 7'h7F, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        read_en("illegal", 0, 0, 0);
        tick();
        offer(enc_r(5'd15, 5'd15, 5'd16), 32'h128, 1,
              mk(32'h128, OP, 5'd16, 1, 1, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0));
        tick();

        // Flush kills x9 entry and its pending bit; same-cycle offer refused
        offer(enc_i(12'd5, 5'd0, 3'd0, 5'd9, OPIMM), 32'h140, 1,
              mk(32'h140, OPIMM, 5'd9, 1, 1, 32'd5, 1, 0, 0, 1, 0, 0, 0, 0, 0));
        tick();
        pipe.flush = 1'b1;
        offer(enc_i(12'd1, 5'd0, 3'd0, 5'd10, OPIMM), 32'h144, 0, none);
        tick();
        chk("flush_ex_valid", pipe.ex_valid, 0);
        offer(enc_r(5'd9, 5'd9, 5'd11), 32'h148, 1,
              mk(32'h148, OP, 5'd11, 1, 1, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0));
        tick();

        // x0 destination never pending
        offer(enc_i(12'd1, 5'd0, 3'd0, 5'd0, OPIMM), 32'h14c, 1,
              mk(32'h14c, OPIMM, 5'd0, 1, 0, 32'd1, 1, 0, 0, 1, 0, 0, 0, 0, 0));
        tick();
        offer(enc_r(5'd0, 5'd0, 5'd1), 32'h150, 1,
              mk(32'h150, OP, 5'd1, 1, 1, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0));
        tick();

        // WAW on x3 (MAC destination, never written back)
        offer(enc_i(12'd2, 5'd0, 3'd0, 5'd3, OPIMM), 32'h154, 0, none);
        tick();
        wb_write_enable = 1'b1; wb_w_addr = 5'd3; wb_w_data = 32'd55;
`ifdef WB_BYPASS_EN
        offer(enc_i(12'd2, 5'd0, 3'd0, 5'd3, OPIMM), 32'h154, 1,
              mk(32'h154, OPIMM, 5'd3, 1, 1, 32'd2, 1, 0, 0, 1, 0, 0, 0, 0, 0));
        tick();
        // Set beat the same-cycle clear: x3 still pending
        offer(enc_r(5'd0, 5'd3, 5'd17), 32'h158, 0, none);
        tick();
`else
        offer(enc_i(12'd2, 5'd0, 3'd0, 5'd3, OPIMM), 32'h154, 0, none);
        tick();
        offer(enc_i(12'd2, 5'd0, 3'd0, 5'd3, OPIMM), 32'h154, 1,
              mk(32'h154, OPIMM, 5'd3, 1, 1, 32'd2, 1, 0, 0, 1, 0, 0, 0, 0, 0));
        tick();
`endif
        tick();
        chk("final_ex_valid", pipe.ex_valid, 0);
        chk("queue_empty", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/id_stage.md
# id_stage

Instruction-decode stage of the pipeline: accepts one fetched instruction per cycle, decodes RV32I plus the custom 3-source MAC, drives the three register-file read ports, and latches operands, immediate and control into the ID/EX register. A 32-bit pending-write scoreboard, cleared by snooping the write-back port, stalls RAW and WAW hazards. Sits between fetch and execute; its read ports face the register file.

## Interface
- No parameters.
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- if_valid  in  1  fetch offers an instruction
- if_instr  in  32  instruction word
- if_pc  in  32  its PC
- id_ready  out  1  instruction accepted this cycle (combinational)
- r1_read_enable / r2_read_enable / r3_read_enable  out  1  read-port enables (combinational)
- r1_addr / r2_addr / r3_addr  out  5  rs1 = [19:15], rs2 = [24:20], rs3 = [31:27]
- r1_data / r2_data / r3_data  in  32  combinational read data
- wb_write_enable  in  1  write-back is writing this cycle
- wb_w_addr  in  5  write-back destination
- wb_w_data  in  32  write-back data
- flush  in  1  kill the ID/EX entry and any same-cycle issue
- ex_ready  in  1  execute consumes the ID/EX entry
- ex_valid  out  1  ID/EX entry valid
- ex_pc, ex_rs1_val, ex_rs2_val, ex_rs3_val, ex_imm  out  32  latched values
- ex_rd  out  5  destination register
- ex_rd_we  out  1  entry writes rd
- ex_opcode  out  7
- ex_funct3  out  3
- ex_funct7  out  7
- ex_is_mac  out  1  entry is a MAC
- ex_illegal  out  1  unknown opcode

## Operation
- Decode by opcode. The listed fields are used; every unlisted source has its read enable at 0.
  - OP 0110011: rs1, rs2, rd.
  - OP-IMM 0010011, LOAD 0000011, JALR 1100111: rs1, rd, I-imm.
  - STORE 0100011: rs1, rs2, S-imm.
  - BRANCH 1100011: rs1, rs2, B-imm.
  - LUI 0110111, AUIPC 0010111: rd, U-imm.
  - JAL 1101111: rd, J-imm.
  - MAC 0001011: rs1, rs2, rs3, rd; ex_is_mac = 1.
- Immediates are sign-extended to 32 bits. U-imm is {instr[31:12], 12'b0}.
- Unknown opcode: no reads, ex_rd_we = 0, ex_illegal = 1. It still issues.
- Read enables are 0 when if_valid = 0 or reset = 1.
- ex_rd_we = 0 whenever rd = 0. Register x0 is never pending and never causes a hazard.
- Scoreboard:
  - On issue with rd_we, set pending[rd].
  - On wb_write_enable with wb_w_addr ≠ 0, clear pending[wb_w_addr].
  - If set and clear hit the same register in the same cycle, set wins.
- hazard = any enabled source with pending[src] = 1, OR rd_we with pending[rd] = 1 (WAW).
- Issue condition: id_ready = if_valid & !hazard & !flush & (!ex_valid | ex_ready).
- On issue: latch all ex_* fields and set ex_valid = 1. If ex_ready = 1 with no issue, clear ex_valid.
- ex_* data fields hold their values while ex_valid = 1 and ex_ready = 0.
- Flush:
  - Clears ex_valid at the next edge.
  - Clears pending[ex_rd] if the killed entry had ex_rd_we = 1.
  - Blocks that cycle's issue.
- Reset mid-operation: at the edge, the scoreboard and ex_valid are cleared; any offered instruction is dropped.

## Timing
- Reset: every output register is 0 (ex_valid, ex_* values, ex_rd_we, ex_is_mac, ex_illegal) and pending = 0.
- Latency: an instruction accepted at edge N is visible on ex_* after edge N.
- Throughput: one instruction per cycle with no hazards.
- RAW stall without bypass: a consumer waits until the cycle after its producer's write-back cycle, then issues and reads the new register-file value.
- Simultaneous flush and ex_ready: flush wins; no issue takes place.

## Configuration
- WB_BYPASS_EN defined:
  - A source equal to wb_w_addr (≠ 0) while wb_write_enable = 1 takes wb_w_data instead of rN_data.
  - That source is not a hazard, so issue happens in the write-back cycle itself.
  - A WAW against that same rd is also not a hazard.
- WB_BYPASS_EN undefined:
  - No forwarding; the stall lasts one more cycle.
  - Read enables and addresses are unchanged.

## Test plan
- Reset, then ADDI x5,x0,7 with ex_ready = 1 -> next cycle ex_valid = 1, ex_rd = 5, ex_imm = 7, ex_rd_we = 1; pending[5] = 1.
- ADD x6,x5,x5 while pending[5] = 1 -> id_ready = 0. With wb_write_enable = 1, wb_w_addr = 5, wb_w_data = 7:
  - With WB_BYPASS_EN: issues that cycle with ex_rs1_val = ex_rs2_val = 7.
  - Without WB_BYPASS_EN: issues one cycle later.
- MAC rd = 3, rs1 = 1, rs2 = 2, rs3 = 4, with register file x1 = 2, x2 = 3, x4 = 10 -> all three read enables = 1; ex_rs1/2/3_val = 2/3/10; ex_is_mac = 1.
- ex_ready = 0 for 3 cycles with a valid entry -> id_ready = 0 and ex_* unchanged; the next instruction issues the cycle ex_ready returns to 1.
- Flush while ex_valid = 1 with ex_rd = 9 -> ex_valid = 0 and pending[9] = 0 next cycle; the instruction offered that cycle is not accepted.
- ADDI x0,x0,1, then ADD x1,x0,x0 in the following cycle -> ex_rd_we = 0 for the first, no stall for the second, ex_rs1_val = 0.
